// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: register offsets,
// STATUS bit positions, counter widths and FSM state encoding.
package uart_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int unsigned STAT_FULL    = 0;
  localparam int unsigned STAT_EMPTY   = 1;
  localparam int unsigned STAT_BUSY    = 2;
  localparam int unsigned STAT_OVF     = 3;
  localparam int unsigned STAT_CNT_LSB = 8;

  // Baud counter sized for CLKS_PER_BIT up to 65535; bit index covers 8 data bits.
  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } uart_state_e;

  localparam logic [2:0] ST_IDLE   = S_IDLE;
  localparam logic [2:0] ST_START  = S_START;
  localparam logic [2:0] ST_DATA   = S_DATA;
  localparam logic [2:0] ST_PARITY = S_PARITY;
  localparam logic [2:0] ST_STOP   = S_STOP;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  // Accept/next-count decode.
  always_comb begin
    pop_ok  = pop && !empty_q;
    push_ok = push && (!full_q || pop_ok);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointers, count and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA/STATUS register window, transmit
// FIFO and 8-bit serialiser. Define UART_TX_PARITY_EN to add an even parity
// bit between the data bits and the stop bit.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  byte_en,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        irq
);

  localparam int unsigned       CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0]       TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + STATUS_OFS;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic              tx_q, tx_d;
  logic              irq_q, irq_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       rd_q, rd_d;
  logic [31:0]       status;

  logic              wr_txdata, wr_ovf_clr;
  logic              pop, push_ok, push_drop;
  logic              baud_last;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_dout;
  logic [CNT_W-1:0]  fifo_count, cnt_next;

  logic              unused_ok;
  assign unused_ok = &{1'b0, wr_data[31:8], byte_en[3:1]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_txdata),
    .pop   (pop),
    .din   (wr_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register decode, overflow tracking, STATUS image and read mux.
  always_comb begin
    wr_txdata  = wr_en && (wr_addr == TXDATA_ADDR) && byte_en[0];
    wr_ovf_clr = wr_en && (wr_addr == STATUS_ADDR) && byte_en[0] && wr_data[3];
    push_drop  = wr_txdata && fifo_full && !pop;
    push_ok    = wr_txdata && !push_drop;
    cnt_next   = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);

    ovf_d = ovf_q;
    if (wr_ovf_clr) ovf_d = 1'b0;
    if (push_drop)  ovf_d = 1'b1;

    status                        = '0;
    status[STAT_CNT_LSB +: 8]     = 8'(fifo_count);
    status[STAT_OVF]              = ovf_q;
    status[STAT_BUSY]             = (state_q != ST_IDLE);
    status[STAT_EMPTY]            = fifo_empty;
    status[STAT_FULL]             = fifo_full;

    rd_d = (rd_addr == STATUS_ADDR) ? status : 32'h0;
  end

  // Frame sequencer; tx and irq are computed from next-state so they line up
  // with the state register.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    data_d    = data_q;
    pop       = 1'b0;
    baud_last = (baud_q == BAUD_LAST);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          data_d  = fifo_dout;
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          bit_d  = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(7)) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            data_d  = fifo_dout;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase

    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[bit_d];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = ^data_d;
`endif
      default:   tx_d = 1'b1;
    endcase

    irq_d = (cnt_next == '0) && (state_d == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
      irq_q   <= 1'b1;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      irq_q   <= irq_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
    end
  end

  assign rd_data = rd_q;
  assign tx      = tx_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: scoreboard of written bytes checked
// by a serial-line monitor, plus cycle-exact frame and register checks.
`timescale 1ns/1ps
module tb_mmio_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS = 11;
`else
  localparam int unsigned NBITS = 10;
`endif
  localparam int unsigned FRAME_CYC = NBITS * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [3:0]  byte_en;
  logic        tx, irq;

  int checks = 0;
  int errors = 0;
  int frames_rx = 0;
  int cyc = 0;
  logic [7:0] sb[$];
  int starts[$];

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .byte_en (byte_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .tx      (tx),
    .irq     (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level for bit slot idx of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[3'(idx - 1)];
    if (NBITS == 11 && idx == 9) return ^b;
    return 1'b1;
  endfunction

  // Serial-line monitor: decodes frames mid-bit and checks against the scoreboard.
  initial begin : monitor
    logic [7:0] got, exp;
    logic       fr_ok, aborted;
    int         bi;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1 && tx === 1'b0) begin
        starts.push_back(cyc);
        got = '0; fr_ok = 1'b1; aborted = 1'b0;
        for (int off = 1; off < int'(FRAME_CYC); off++) begin
          @(negedge clk);
          if (rst === 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (off % int'(CPB) == int'(CPB / 2)) begin
            bi = off / int'(CPB);
            if (bi == 0) begin
              if (tx !== 1'b0) fr_ok = 1'b0;
            end else if (bi <= 8) begin
              got[3'(bi - 1)] = tx;
            end else if (tx !== exp_bit(got, bi)) begin
              fr_ok = 1'b0;
            end
          end
        end
        if (!aborted) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL frame_unexpected: got byte %h, expected no frame", got);
          end else begin
            exp = sb.pop_front();
            frames_rx++;
            if (got !== exp || !fr_ok) begin
              errors++;
              $display("FAIL frame_data: got %h framing_ok=%0d, expected %h framing_ok=1",
                       got, fr_ok, exp);
            end
          end
        end
      end
    end
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; byte_en = be;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (!(irq === 1'b1 && sb.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_drain_timeout: irq=%b pending=%0d, expected irq=1 pending=0",
               tag, irq, sb.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; byte_en = '0; rd_addr = A_ST;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || irq !== 1'b1 || rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: tx=%b irq=%b rd_data=%h, expected 1 1 00000000", tx, irq, rd_data);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_data !== 32'h2) begin
      errors++;
      $display("FAIL reset_status: got %h expected 00000002", rd_data);
    end
  endtask

  task automatic test_ignored;
    bus_wr(BASE + 32'h8, 32'h41, 4'hF);
    bus_wr(A_TX, 32'h42, 4'b0010);
    rd_addr = A_ST;
    repeat (3) @(negedge clk);
    checks++;
    if (rd_data !== 32'h2 || tx !== 1'b1 || irq !== 1'b1) begin
      errors++;
      $display("FAIL ignored_writes: status=%h tx=%b irq=%b, expected 00000002 1 1", rd_data, tx, irq);
    end
    rd_addr = BASE + 32'h8;
    @(negedge clk);
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL read_unmapped: got %h expected 00000000", rd_data);
    end
    rd_addr = A_TX;
    @(negedge clk);
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL read_txdata: got %h expected 00000000", rd_data);
    end
  endtask

  // Cycle-exact waveform, busy length and irq timing of a single frame.
  task automatic test_frame(input logic [7:0] b);
    int   busy_cnt;
    logic e;
    rd_addr = A_ST;
    sb.push_back(b);
    bus_wr(A_TX, {24'h0, b}, 4'hF);
    busy_cnt = 0;
    for (int c = 1; c <= int'(FRAME_CYC) + 8; c++) begin
      if (c <= int'(FRAME_CYC) + 2) begin
        if (c < 2 || c >= int'(FRAME_CYC) + 2) e = 1'b1;
        else e = exp_bit(b, (c - 2) / int'(CPB));
        checks++;
        if (tx !== e) begin
          errors++;
          $display("FAIL frame_%h_tx_cycle%0d: got %b expected %b", b, c, tx, e);
        end
      end
      if (c == 1 || c == int'(FRAME_CYC) + 1 || c == int'(FRAME_CYC) + 2) begin
        e = (c == int'(FRAME_CYC) + 2);
        checks++;
        if (irq !== e) begin
          errors++;
          $display("FAIL frame_%h_irq_cycle%0d: got %b expected %b", b, c, irq, e);
        end
      end
      if (rd_data[2] === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != int'(FRAME_CYC)) begin
      errors++;
      $display("FAIL frame_%h_busy_len: got %0d expected %0d", b, busy_cnt, FRAME_CYC);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL frame_%h_not_seen: pending=%0d expected 0", b, sb.size());
    end
  endtask

  // Nine bytes back-to-back drain gap-free; ten more into a full FIFO overflow.
  task automatic test_overflow;
    int f0;
    f0 = frames_rx;
    starts.delete();
    rd_addr = A_ST;
    for (int i = 0; i < 9; i++) begin
      sb.push_back(8'(8'h10 + i));
      bus_wr(A_TX, 32'(8'h10 + i), 4'hF);
    end
    for (int i = 0; i < 10; i++) bus_wr(A_TX, 32'(8'hE0 + i), 4'hF);
    checks++;
    if (rd_data !== 32'h0000_080D) begin
      errors++;
      $display("FAIL overflow_status: got %h expected 0000080D", rd_data);
    end
    wait_drain("overflow");
    checks++;
    if (frames_rx - f0 != 9) begin
      errors++;
      $display("FAIL overflow_frames: got %0d expected 9", frames_rx - f0);
    end
    checks++;
    if (starts.size() != 9 || starts[starts.size() - 1] - starts[0] != 8 * int'(FRAME_CYC)) begin
      errors++;
      $display("FAIL back_to_back_gap: starts=%0d span=%0d expected 9 and %0d",
               starts.size(), (starts.size() > 0) ? starts[starts.size() - 1] - starts[0] : -1,
               8 * FRAME_CYC);
    end
    checks++;
    if (rd_data !== 32'h0000_000A) begin
      errors++;
      $display("FAIL overflow_sticky: got %h expected 0000000A", rd_data);
    end
  endtask

  task automatic test_clear_overflow;
    rd_addr = A_ST;
    bus_wr(A_ST, 32'h8, 4'h1);
    checks++;
    if (rd_data[3] !== 1'b1) begin
      errors++;
      $display("FAIL clear_before: overflow=%b expected 1", rd_data[3]);
    end
    @(negedge clk);
    checks++;
    if (rd_data !== 32'h2) begin
      errors++;
      $display("FAIL clear_after: got %h expected 00000002", rd_data);
    end
  endtask

  // Continuous writes: only the write coinciding with the STOP-exit pop is
  // accepted once the FIFO has filled.
  task automatic test_full_pop;
    int f0;
    f0 = frames_rx;
    rd_addr = A_ST;
    for (int i = 0; i <= int'(FRAME_CYC) + 4; i++) begin
      if (i <= int'(DEPTH) || i == int'(FRAME_CYC) + 1) sb.push_back(8'(8'h40 + i));
      bus_wr(A_TX, 32'(8'h40 + i), 4'hF);
    end
    checks++;
    if (rd_data !== 32'h0000_080D) begin
      errors++;
      $display("FAIL full_pop_status: got %h expected 0000080D", rd_data);
    end
    wait_drain("full_pop");
    checks++;
    if (frames_rx - f0 != int'(DEPTH) + 2) begin
      errors++;
      $display("FAIL full_pop_frames: got %0d expected %0d", frames_rx - f0, DEPTH + 2);
    end
  endtask

  task automatic test_reset_mid;
    rd_addr = A_ST;
    sb.push_back(8'hA5);
    bus_wr(A_TX, 32'hA5, 4'hF);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || rd_data !== 32'h0 || irq !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_outputs: tx=%b rd_data=%h irq=%b, expected 1 00000000 1", tx, rd_data, irq);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    if (rd_data !== 32'h2 || irq !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_status: status=%h irq=%b tx=%b, expected 00000002 1 1", rd_data, irq, tx);
    end
    sb.push_back(8'h3C);
    bus_wr(A_TX, 32'h3C, 4'hF);
    wait_drain("reset_mid");
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_ignored();
    test_frame(8'h55);
`ifdef UART_TX_PARITY_EN
    test_frame(8'h07);
`endif
    test_overflow();
    test_clear_overflow();
    test_full_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
